// File: rtl/mult_control_if.sv
// Handshake bundle between the switch/button synchronisers, the multiply
// sequencer and the A/B/X register datapath.
interface mult_control_if #(
    parameter int CNT_W = 3
);
    logic             Run;
    logic             ClearA_LoadB;
    logic             M;
    logic             Clr_Ld;
    logic             Clear_AX;
    logic             Add_En;
    logic             Sub_En;
    logic             Shift_En;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Iter;

    modport master (
        output Run, ClearA_LoadB, M,
        input  Clr_Ld, Clear_AX, Add_En, Sub_En, Shift_En, Busy, Done, Iter
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output Clr_Ld, Clear_AX, Add_En, Sub_En, Shift_En, Busy, Done, Iter
    );
endinterface

// File: rtl/mult_control.sv
// Sequencer for the shift-add two's-complement multiplier: N add/shift
// iterations per Run press, with the last iteration subtracting.
module mult_control #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N)
) (
    input  logic           Clk,
    input  logic           Reset_n,
    mult_control_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOADB,
        CLEAR,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] iter;
    logic [CNT_W-1:0] iter_nxt;
    logic             run_q;
    logic             clrld_q;
    logic             run_rise;
    logic             clrld_rise;
    logic             last_iter;

    logic             clr_ld;
    logic             clear_ax;
    logic             add_en;
    logic             sub_en;
    logic             shift_en;
    logic             busy;
    logic             done;

    // Edge-qualifier flops reset high so an input held through reset
    // cannot start anything until it is released and pressed again.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            iter    <= '0;
            run_q   <= 1'b1;
            clrld_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            iter    <= iter_nxt;
            run_q   <= bus.Run;
            clrld_q <= bus.ClearA_LoadB;
        end
    end

    assign run_rise   = bus.Run & ~run_q;
    assign clrld_rise = bus.ClearA_LoadB & ~clrld_q;
    assign last_iter  = (iter == LAST_ITER);

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        clr_ld    = 1'b0;
        clear_ax  = 1'b0;
        add_en    = 1'b0;
        sub_en    = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state)
            IDLE: begin
                if (run_rise) begin
                    state_nxt = CLEAR;
                end else if (clrld_rise) begin
                    state_nxt = LOADB;
                end
            end
            LOADB: begin
                clr_ld    = 1'b1;
                state_nxt = IDLE;
            end
            CLEAR: begin
                clear_ax  = 1'b1;
                busy      = 1'b1;
                iter_nxt  = '0;
                state_nxt = EVAL;
            end
            // The final partial product carries the sign weight, so it is
            // subtracted instead of added.
            EVAL: begin
                busy      = 1'b1;
                add_en    = bus.M & ~last_iter;
                sub_en    = bus.M & last_iter;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end else begin
                    iter_nxt  = iter + CNT_W'(1);
                    state_nxt = EVAL;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!bus.Run) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Clr_Ld   = clr_ld;
    assign bus.Clear_AX = clear_ax;
    assign bus.Add_En   = add_en;
    assign bus.Sub_En   = sub_en;
    assign bus.Shift_En = shift_en;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.Iter     = iter;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: a timeline model of one multiply (phase number
// since the Run edge) checked every cycle, plus directed literal counts.
module tb_mult_control;

    localparam int N     = 8;
    localparam int CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mult_control_if #(.CNT_W(CNT_W)) bus ();

    mult_control #(.N(N), .CNT_W(CNT_W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: phase 0 = idle, 1 = clear, 2..2N+1 = eval/shift, 2N+2 = done.
    int         phase;
    logic       load_pulse;
    logic       run_prev;
    logic       clr_prev;
    int         iter_hold;
    logic [7:0] b_op;
    logic       rand_op;

    // Observation bookkeeping for directed checks.
    int   cyc;
    int   start_cyc;
    int   done_at;
    logic done_seen;
    int   add_cnt, sub_cnt, shift_cnt, clrld_cnt, clear_cnt;

    function automatic logic [9:0] observed();
        return {bus.Clr_Ld, bus.Clear_AX, bus.Add_En, bus.Sub_En, bus.Shift_En,
                bus.Busy, bus.Done, bus.Iter};
    endfunction

    function automatic logic [9:0] expected();
        logic ev, sh, m;
        int   it;
        ev = (phase >= 2) && (phase <= 2*N) && (phase % 2 == 0);
        sh = (phase >= 3) && (phase <= 2*N+1) && (phase % 2 == 1);
        m  = bus.M;
        if (ev)                 it = (phase - 2) / 2;
        else if (sh)            it = (phase - 3) / 2;
        else if (phase == 2*N+2) it = N - 1;
        else                    it = iter_hold;
        return {load_pulse, phase == 1, ev && m && (it != N-1), ev && m && (it == N-1),
                sh, (phase >= 1) && (phase <= 2*N+1), phase == 2*N+2, 3'(it)};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d phase=%0d got=%b want=%b (ld,clr,add,sub,sh,busy,done,iter)",
                     name, cyc, phase, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        phase      = 0;
        load_pulse = 1'b0;
        run_prev   = 1'b1;
        clr_prev   = 1'b1;
        iter_hold  = 0;
    endtask

    task automatic clear_counts();
        add_cnt = 0; sub_cnt = 0; shift_cnt = 0; clrld_cnt = 0; clear_cnt = 0;
        done_seen = 1'b0; done_at = -1;
    endtask

    // Compare the current cycle against the model and tally observed pulses.
    task automatic compare_now();
        logic [9:0] e, o;
        e = expected();
        o = observed();
        check("outputs", o, e);
        iter_hold = int'(e[2:0]);
        if (o[9]) clrld_cnt++;
        if (o[8]) clear_cnt++;
        if (o[7]) add_cnt++;
        if (o[6]) sub_cnt++;
        if (o[5]) shift_cnt++;
        if (o[3] && !done_seen) begin
            done_seen = 1'b1;
            done_at   = cyc - start_cyc;
        end
    endtask

    task automatic advance();
        logic run, clr;
        run = bus.Run;
        clr = bus.ClearA_LoadB;
        if (load_pulse) begin
            load_pulse = 1'b0;
        end else if (phase == 0) begin
            if (run && !run_prev) begin
                phase     = 1;
                start_cyc = cyc;
                if (rand_op) b_op = 8'($urandom);
            end else if (clr && !clr_prev) begin
                load_pulse = 1'b1;
            end
        end else if (phase <= 2*N+1) begin
            phase++;
        end else if (!run) begin
            phase = 0;
        end
        run_prev = run;
        clr_prev = clr;
    endtask

    task automatic step(input logic run, input logic clr);
        @(negedge clk);
        bus.Run          = run;
        bus.ClearA_LoadB = clr;
        if ((phase >= 2) && (phase <= 2*N) && (phase % 2 == 0))
            bus.M = b_op[(phase-2)/2];
        else
            bus.M = 1'($urandom);
        #1;
        compare_now();
        @(posedge clk);
        advance();
        cyc++;
    endtask

    // Assert reset between edges: outputs must fall with no clock edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        compare_now();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", observed(), 10'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_held_outputs", observed(), 10'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic run_until_phase(input int target);
        int guard;
        guard = 0;
        while (phase != target && guard < 40) begin
            step(1'b1, 1'b0);
            guard++;
        end
        if (phase != target) begin
            miscompares++;
            $display("FAIL wait_phase%0d timeout phase=%0d", target, phase);
        end
    endtask

    initial begin
        cyc = 0; start_cyc = 0; rand_op = 1'b0; b_op = 8'h00;
        clear_counts();
        bus.Run = 1'b1; bus.ClearA_LoadB = 1'b1; bus.M = 1'b0;
        model_reset();

        // Reset held with both buttons high.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_outputs", observed(), 10'b0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_counts();
        repeat (4) step(1'b1, 1'b1);
        check_int("no_start_after_reset", clear_cnt + clrld_cnt, 0);
        repeat (2) step(1'b0, 1'b0);

        // Load request held for 5 cycles gives one Clr_Ld pulse.
        clear_counts();
        repeat (5) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check_int("load_pulse_count", clrld_cnt, 1);

        // Positive multiplier B=0x07.
        b_op = 8'h07;
        clear_counts();
        repeat (21) step(1'b1, 1'b0);
        check_int("pos_add_count", add_cnt, 3);
        check_int("pos_sub_count", sub_cnt, 0);
        check_int("pos_shift_count", shift_cnt, N);
        check_int("pos_done_cycle", done_at, 2*N+2);

        // Hold Run after Done: no new multiply.
        clear_counts();
        repeat (10) step(1'b1, 1'b1);
        check_int("hold_no_clear", clear_cnt, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Negative multiplier B=0x81 on a fresh Run edge.
        b_op = 8'h81;
        clear_counts();
        repeat (21) step(1'b1, 1'b0);
        check_int("neg_add_count", add_cnt, 1);
        check_int("neg_sub_count", sub_cnt, 1);
        check_int("neg_done_cycle", done_at, 2*N+2);
        step(1'b0, 1'b0);

        // Abort at cycle 9 with Run held; no restart until Run is re-pressed.
        b_op = 8'hA5;
        step(1'b1, 1'b0);
        run_until_phase(9);
        async_reset();
        clear_counts();
        repeat (5) step(1'b1, 1'b0);
        check_int("abort_no_restart", clear_cnt + done_seen, 0);
        step(1'b0, 1'b0);
        clear_counts();
        repeat (21) step(1'b1, 1'b0);
        check_int("restart_done_cycle", done_at, 2*N+2);
        step(1'b0, 1'b0);

        // Randomized traffic with random operands and occasional aborts.
        rand_op = 1'b1;
        begin
            logic run, clr;
            run = 1'b0;
            clr = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) run = ~run;
                if ($urandom_range(0, 5) == 0) clr = ~clr;
                if ($urandom_range(0, 299) == 0) async_reset();
                else step(run, clr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
